// File: rtl/red_pitaya_pwm_bank.sv
// -----------------------------------------------------------------------------
// red_pitaya_pwm_bank
//   Bank of CH pulse-width-modulated DAC outputs with DW-bit resolution.
//   A free-running DW-bit counter defines a 2^DW-cycle period. Each channel
//   has a bus-written target duty and an active duty. The active duty is
//   reloaded only at the period boundary, so a waveform never changes shape
//   mid-period.
//
//   Optional build macro: PWM_SLEW_EN
//     When defined, the active duty moves toward the target by at most STEP
//     per period. When undefined, the target is loaded directly and STEP is
//     only a read/write register field.
//
// Ports
//   clk_i      system clock
//   rstn_i     asynchronous active-low reset
//   sys_addr   bus address, only [7:0] decoded
//   sys_wdata  bus write data (full-word writes)
//   sys_sel    byte selects, unused
//   sys_wen    write strobe (1 cycle)
//   sys_ren    read strobe (1 cycle)
//   sys_rdata  read data, valid while sys_ack is high, held otherwise
//   sys_err    bus error, always 0
//   sys_ack    acknowledge, one cycle after every strobe
//   dac_o      PWM outputs, bit n drives channel n
//   period_o   one-cycle strobe following each period boundary
//
// Register map (byte offsets)
//   0x00         CTRL   [0] EN, [31:16] STEP
//   0x04         STATUS [CH-1:0] BUSY, [31:16] counter
//   0x20 + 4*n   CHn    write: target duty; read: {active, target}
// -----------------------------------------------------------------------------
module red_pitaya_pwm_bank #(
  parameter int CH = 4,
  parameter int DW = 8
) (
  input  logic          clk_i,
  input  logic          rstn_i,
  input  logic [31:0]   sys_addr,
  input  logic [31:0]   sys_wdata,
  input  logic [3:0]    sys_sel,
  input  logic          sys_wen,
  input  logic          sys_ren,
  output logic [31:0]   sys_rdata,
  output logic          sys_err,
  output logic          sys_ack,
  output logic [CH-1:0] dac_o,
  output logic          period_o
);

  localparam logic [DW-1:0] CNT_MAX = '1;
  localparam logic [3:0]    CH_L    = 4'(CH);

  logic          en;
  logic [15:0]   step;
  logic [DW-1:0] cnt;
  logic [DW-1:0] target [CH];
  logic [DW-1:0] active [CH];
  logic [CH-1:0] busy;
  logic          boundary;

  logic [7:0]    addr;
  logic [2:0]    ch_idx;
  logic          is_ctrl;
  logic          is_stat;
  logic          is_ch;
  logic [31:0]   rd;

  // Upper address bits, byte selects and unused data bits are don't-care.
  logic          unused_ok;
  assign unused_ok = ^{sys_sel, sys_addr, sys_wdata};

  assign sys_err  = 1'b0;
  assign boundary = en && (cnt == CNT_MAX);

`ifdef PWM_SLEW_EN
  // Move act toward tgt by at most stp. The DW+1-bit sum cannot leave the
  // DW-bit range when stp < distance, but is clamped anyway.
  function automatic logic [DW-1:0] slew_limit(input logic [DW-1:0] act,
                                               input logic [DW-1:0] tgt,
                                               input logic [DW-1:0] stp);
    logic [DW:0] dist;
    logic [DW:0] moved;
    dist  = (tgt >= act) ? ({1'b0, tgt} - {1'b0, act})
                         : ({1'b0, act} - {1'b0, tgt});
    moved = (tgt > act)  ? ({1'b0, act} + {1'b0, stp})
                         : ({1'b0, act} - {1'b0, stp});
    if (stp == '0 || dist <= {1'b0, stp})
      return tgt;
    if (moved[DW])
      return (tgt > act) ? '1 : '0;
    return moved[DW-1:0];
  endfunction
`endif

  // Address decode on the low byte; channel slots must be word aligned.
  always_comb begin
    addr    = sys_addr[7:0];
    ch_idx  = addr[4:2];
    is_ctrl = (addr == 8'h00);
    is_stat = (addr == 8'h04);
    is_ch   = (addr[7:5] == 3'b001) && (addr[1:0] == 2'b00) &&
              ({1'b0, addr[4:2]} < CH_L);
  end

  always_comb begin
    busy = '0;
    for (int n = 0; n < CH; n++)
      busy[n] = (active[n] != target[n]);
  end

  always_comb begin
    rd = '0;
    if (is_ctrl) begin
      rd = {step, 15'd0, en};
    end else if (is_stat) begin
      rd[31:16]   = 16'(cnt);
      rd[CH-1:0]  = busy;
    end else if (is_ch) begin
      for (int n = 0; n < CH; n++) begin
        if (ch_idx == 3'(n)) begin
          rd[31:16] = 16'(active[n]);
          rd[15:0]  = 16'(target[n]);
        end
      end
    end
  end

  // Bus stage: register writes, read data capture and acknowledge.
  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      en        <= 1'b0;
      step      <= '0;
      sys_ack   <= 1'b0;
      sys_rdata <= '0;
      for (int n = 0; n < CH; n++)
        target[n] <= '0;
    end else begin
      sys_ack <= sys_wen | sys_ren;
      if (sys_ren)
        sys_rdata <= rd;
      if (sys_wen) begin
        if (is_ctrl) begin
          en   <= sys_wdata[0];
          step <= sys_wdata[31:16];
        end
        for (int n = 0; n < CH; n++)
          if (is_ch && (ch_idx == 3'(n)))
            target[n] <= sys_wdata[DW-1:0];
      end
    end
  end

  // PWM stage: counter, boundary reload of active duties, output compare.
  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      cnt      <= '0;
      period_o <= 1'b0;
      dac_o    <= '0;
      for (int n = 0; n < CH; n++)
        active[n] <= '0;
    end else begin
      cnt      <= en ? cnt + 1'b1 : '0;
      period_o <= boundary;
      for (int n = 0; n < CH; n++) begin
        dac_o[n] <= en && (cnt < active[n]);
        if (!en) begin
          active[n] <= target[n];
        end else if (boundary) begin
`ifdef PWM_SLEW_EN
          active[n] <= slew_limit(active[n], target[n], step[DW-1:0]);
`else
          active[n] <= target[n];
`endif
        end
      end
    end
  end

endmodule

// File: tb/tb_red_pitaya_pwm_bank.sv
// -----------------------------------------------------------------------------
// tb_red_pitaya_pwm_bank
//   Scoreboard bench for red_pitaya_pwm_bank (CH=4, DW=8). Bus transactions
//   push their expected response; a negedge monitor pops on every sys_ack.
//   PWM windows (period_o to period_o) push expected high-cycle counts that
//   the monitor compares when the window closes.
// -----------------------------------------------------------------------------
module tb_red_pitaya_pwm_bank;

  localparam int CH = 4;
  localparam int DW = 8;

  logic          clk_i = 1'b0;
  logic          rstn_i = 1'b0;
  logic [31:0]   sys_addr = '0;
  logic [31:0]   sys_wdata = '0;
  logic [3:0]    sys_sel = 4'hF;
  logic          sys_wen = 1'b0;
  logic          sys_ren = 1'b0;
  logic [31:0]   sys_rdata;
  logic          sys_err;
  logic          sys_ack;
  logic [CH-1:0] dac_o;
  logic          period_o;

  red_pitaya_pwm_bank #(.CH(CH), .DW(DW)) dut (
    .clk_i     (clk_i),
    .rstn_i    (rstn_i),
    .sys_addr  (sys_addr),
    .sys_wdata (sys_wdata),
    .sys_sel   (sys_sel),
    .sys_wen   (sys_wen),
    .sys_ren   (sys_ren),
    .sys_rdata (sys_rdata),
    .sys_err   (sys_err),
    .sys_ack   (sys_ack),
    .dac_o     (dac_o),
    .period_o  (period_o)
  );

  always #4 clk_i = ~clk_i;

  typedef struct {
    logic        rd;
    logic [31:0] data;
    int          issue;
    string       name;
  } bus_t;

  typedef struct {
    logic [3:0][15:0] hi;
  } pwm_t;

  bus_t bus_q[$];
  pwm_t pwm_q[$];

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  always @(posedge clk_i) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  // Monitor: bus acknowledges and PWM period windows.
  bus_t mt;
  pwm_t mp;
  int   hi_cnt[CH];
  int   win_len = 0;
  bit   win_open = 1'b0;

  always @(negedge clk_i) begin
    if (sys_ack) begin
      if (bus_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_ack: got ack with no pending transaction");
      end else begin
        mt = bus_q.pop_front();
        check({mt.name, "_ack_latency"}, cyc, mt.issue + 1);
        check({mt.name, "_err"}, 32'(sys_err), 32'h0);
        if (mt.rd)
          check(mt.name, sys_rdata, mt.data);
      end
    end
    if (period_o) begin
      if (win_open && pwm_q.size() > 0) begin
        mp = pwm_q.pop_front();
        check("period_len", win_len, 256);
        for (int n = 0; n < CH; n++)
          check($sformatf("pwm_ch%0d_high", n), hi_cnt[n], 32'(mp.hi[n]));
      end
      win_open = 1'b1;
      win_len  = 0;
      for (int n = 0; n < CH; n++) hi_cnt[n] = 0;
    end
    if (win_open) begin
      win_len++;
      for (int n = 0; n < CH; n++) hi_cnt[n] += int'(dac_o[n]);
    end
  end

  task automatic push_bus(input logic rd, input logic [31:0] d, input string name);
    bus_t t;
    t.rd = rd;
    t.data = d;
    t.issue = cyc;
    t.name = name;
    bus_q.push_back(t);
  endtask

  task automatic bus_write(input logic [31:0] a, input logic [31:0] d);
    @(posedge clk_i); #1;
    sys_addr = a; sys_wdata = d; sys_wen = 1'b1;
    push_bus(1'b0, 32'h0, $sformatf("wr_%02h", a[7:0]));
    @(posedge clk_i); #1;
    sys_wen = 1'b0;
  endtask

  task automatic bus_read(input logic [31:0] a, input logic [31:0] exp, input string name);
    @(posedge clk_i); #1;
    sys_addr = a; sys_ren = 1'b1;
    push_bus(1'b1, exp, name);
    @(posedge clk_i); #1;
    sys_ren = 1'b0;
  endtask

  task automatic bus_rw(input logic [31:0] a, input logic [31:0] d, input string name);
    @(posedge clk_i); #1;
    sys_addr = a; sys_wdata = d; sys_wen = 1'b1; sys_ren = 1'b1;
    push_bus(1'b0, 32'h0, name);
    @(posedge clk_i); #1;
    sys_wen = 1'b0; sys_ren = 1'b0;
  endtask

  task automatic push_pwm(input logic [15:0] h0, input logic [15:0] h1,
                          input logic [15:0] h2, input logic [15:0] h3);
    pwm_t p;
    p.hi[0] = h0; p.hi[1] = h1; p.hi[2] = h2; p.hi[3] = h3;
    pwm_q.push_back(p);
  endtask

  // Returns just after the negedge of the period_o cycle (counter = 0).
  task automatic wait_pulse();
    int k = 0;
    do begin
      @(negedge clk_i);
      k++;
    end while (!period_o && k < 600);
    if (!period_o) begin
      checks++;
      errors++;
      $display("FAIL pulse_timeout: got no period_o within 600 cycles, required one");
    end
    #1;
  endtask

  task automatic wait_drain();
    int k = 0;
    while (bus_q.size() != 0 && k < 20) begin
      @(negedge clk_i);
      k++;
    end
    if (bus_q.size() != 0) begin
      checks++;
      errors++;
      $display("FAIL ack_timeout: got %0d pending transactions, required 0", bus_q.size());
      bus_q.delete();
    end
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk_i);
  endtask

  // One period of the duty sequence on channel 0 (ch1=0, ch2=255, ch3=0).
  task automatic slew_step(input logic [15:0] act, input logic [15:0] tgt);
    wait_pulse();
    push_pwm(act, 16'd0, 16'd255, 16'd0);
    bus_read(32'h20, {act, tgt}, $sformatf("ch0_act%0d", act));
    bus_read(32'h04, {16'd3, 15'd0, (act != tgt)}, $sformatf("status_act%0d", act));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $display("Simulation finished: %0d checks, %0d errors", checks, errors + 1);
    $fatal(1, "watchdog");
  end

  initial begin
    bit saw_p;
    bit saw_d;

    // Reset state
    repeat (3) @(posedge clk_i);
    #1;
    check("rst_dac", 32'(dac_o), 32'h0);
    check("rst_period", 32'(period_o), 32'h0);
    check("rst_ack", 32'(sys_ack), 32'h0);
    check("rst_rdata", sys_rdata, 32'h0);
    @(negedge clk_i);
    rstn_i = 1'b1;

    bus_read(32'h00, 32'h0, "ctrl_reset");
    bus_read(32'h04, 32'h0, "status_reset");
    bus_read(32'h20, 32'h0, "ch0_reset");

    // Enable, then program targets; active stays 0 until the first boundary.
    bus_write(32'h00, 32'h1);
    bus_write(32'h20, 32'd64);
    bus_write(32'h24, 32'd0);
    bus_write(32'h28, 32'd255);
    bus_read(32'h20, 32'h0000_0040, "ch0_before_load");
    bus_read(32'h04, 32'h0009_0005, "status_busy");

    wait_pulse();
    push_pwm(16'd64, 16'd0, 16'd255, 16'd0);
    bus_read(32'h28, 32'h00FF_00FF, "ch2_loaded");
    bus_read(32'h24, 32'h0000_0000, "ch1_loaded");
    bus_read(32'h20, 32'h0040_0040, "ch0_loaded");
    bus_read(32'h04, 32'h0007_0000, "status_idle");

    wait_pulse();
    push_pwm(16'd64, 16'd0, 16'd255, 16'd0);

    // Mid-period target change at cnt=100 applies only at the next boundary.
    wait_pulse();
    push_pwm(16'd64, 16'd0, 16'd255, 16'd0);
    idle(99);
    bus_write(32'h20, 32'd200);
    bus_read(32'h20, 32'h0040_00C8, "ch0_pending");
    bus_read(32'h04, 32'h0068_0001, "status_pending");

    wait_pulse();
    push_pwm(16'd200, 16'd0, 16'd255, 16'd0);
    bus_read(32'h20, 32'h00C8_00C8, "ch0_new_load");

    wait_pulse();
    push_pwm(16'd200, 16'd0, 16'd255, 16'd0);
    bus_write(32'h00, 32'h0032_0001);
    bus_write(32'h20, 32'd0);
    bus_read(32'h00, 32'h0032_0001, "ctrl_step");
`ifdef PWM_SLEW_EN
    slew_step(16'd150, 16'd0);
    slew_step(16'd100, 16'd0);
    slew_step(16'd50,  16'd0);
    slew_step(16'd0,   16'd0);
    bus_write(32'h20, 32'd200);
    slew_step(16'd50,  16'd200);
    slew_step(16'd100, 16'd200);
    slew_step(16'd150, 16'd200);
    slew_step(16'd200, 16'd200);
`else
    slew_step(16'd0,   16'd0);
    bus_write(32'h20, 32'd200);
    slew_step(16'd200, 16'd200);
`endif
    bus_write(32'h20, 32'd180);
    slew_step(16'd180, 16'd180);

    // Clear EN at cnt=37.
    wait_pulse();
    idle(36);
    bus_write(32'h00, 32'h0);
    @(posedge clk_i); #1;
    check("dac_after_disable", 32'(dac_o), 32'h0);
    bus_read(32'h04, 32'h0, "status_disabled");
    saw_p = 1'b0;
    saw_d = 1'b0;
    repeat (300) begin
      @(negedge clk_i);
      if (period_o) saw_p = 1'b1;
      if (dac_o != '0) saw_d = 1'b1;
    end
    check("period_silent", 32'(saw_p), 32'h0);
    check("dac_silent", 32'(saw_d), 32'h0);

    // Unmapped offsets, combined strobe, ignored write.
    bus_read(32'h100, 32'h0, "rd_0x100");
    bus_read(32'h30, 32'h0, "rd_0x30");
    bus_read(32'h10, 32'h0, "rd_0x10");
    bus_rw(32'h2C, 32'h55, "wr_rd_ch3");
    bus_read(32'h2C, 32'h0055_0055, "ch3_after_wr_rd");
    bus_write(32'h30, 32'hAB);
    bus_read(32'h30, 32'h0, "rd_0x30_after_wr");

    // Asynchronous reset while channel 0 is high.
    bus_write(32'h00, 32'h1);
    wait_pulse();
    bus_read(32'h28, 32'h00FF_00FF, "ch2_pre_reset");
    wait_drain();
    idle(3);
    #1;
    check("dac0_pre_reset", 32'(dac_o[0]), 32'h1);
    #2;
    rstn_i = 1'b0;
    #1;
    check("arst_dac", 32'(dac_o), 32'h0);
    check("arst_period", 32'(period_o), 32'h0);
    check("arst_ack", 32'(sys_ack), 32'h0);
    check("arst_rdata", sys_rdata, 32'h0);
    @(negedge clk_i);
    rstn_i = 1'b1;
    bus_read(32'h20, 32'h0, "ch0_after_arst");
    bus_read(32'h00, 32'h0, "ctrl_after_arst");
    bus_read(32'h04, 32'h0, "status_after_arst");
    wait_drain();

    if (pwm_q.size() != 0) begin
      checks++;
      errors++;
      $display("FAIL pwm_windows: got %0d unchecked windows, required 0", pwm_q.size());
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
